// File: rtl/axi_master_pkg.sv
// Shared definitions for axi_lite_master: FSM state encoding and the default
// channel widths / watchdog limit used as parameter defaults by the master.
package axi_master_pkg;

  localparam int AXI_ADDR_W_DEF         = 32;
  localparam int AXI_DATA_W_DEF         = 32;
  localparam int AXI_TIMEOUT_CYCLES_DEF = 256;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    RESP
  } axi_master_state_e;

endpackage

// File: rtl/axi_lite_master.sv
// axi_lite_master
//   Single-outstanding AXI-lite style master in front of the axi_slave
//   register block. A command (cmd_*) becomes either an AW/W/B write or an
//   AR/R read; the result is returned on resp_*. Every output is registered.
//
// Ports
//   ACLK, ARESET          clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (cmd_ready high only in IDLE)
//   cmd_write/addr/wdata  command payload (1 = write)
//   resp_valid/resp_ready response handshake
//   resp_write/resp_rdata response payload (rdata is 0 for writes)
//   AW*, W*, B*           write address / data / response channels
//   AR*, R*               read address / data channels
//   resp_err              watchdog expiry flag (AXI_MASTER_TIMEOUT_EN only)
//
// Build option
//   AXI_MASTER_TIMEOUT_EN  adds the TIMEOUT_CYCLES parameter, a wait-state
//                          watchdog and the resp_err port. Without it the
//                          master waits indefinitely on the slave.
module axi_lite_master
  import axi_master_pkg::*;
#(
  parameter int ADDR_W = AXI_ADDR_W_DEF,
  parameter int DATA_W = AXI_DATA_W_DEF
`ifdef AXI_MASTER_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = AXI_TIMEOUT_CYCLES_DEF
`endif
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_write,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] AWADDR,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic              BVALID,
  output logic              BREADY,
  output logic [ADDR_W-1:0] ARADDR,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [DATA_W-1:0] RDATA,
  input  logic              RVALID,
  output logic              RREADY
`ifdef AXI_MASTER_TIMEOUT_EN
  , output logic            resp_err
`endif
);

  axi_master_state_e state_q, state_d;

  logic              cmd_ready_d;
  logic              resp_valid_d;
  logic              resp_write_d;
  logic [DATA_W-1:0] resp_rdata_d;
  logic [ADDR_W-1:0] awaddr_d;
  logic              awvalid_d;
  logic [DATA_W-1:0] wdata_d;
  logic              wvalid_d;
  logic              bready_d;
  logic [ADDR_W-1:0] araddr_d;
  logic              arvalid_d;
  logic              rready_d;

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int              CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]   TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          wr_q, wr_d;
  logic          resp_err_d;
  logic          in_wait;
`endif

  // Next-state and next-output logic; outputs are then registered below.
  always_comb begin
    state_d      = state_q;
    resp_valid_d = resp_valid;
    resp_write_d = resp_write;
    resp_rdata_d = resp_rdata;
    awaddr_d     = AWADDR;
    awvalid_d    = AWVALID;
    wdata_d      = WDATA;
    wvalid_d     = WVALID;
    bready_d     = BREADY;
    araddr_d     = ARADDR;
    arvalid_d    = ARVALID;
    rready_d     = RREADY;
`ifdef AXI_MASTER_TIMEOUT_EN
    wr_d         = wr_q;
    resp_err_d   = resp_err;
    tmo_cnt_d    = tmo_cnt_q;
    in_wait      = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
`ifdef AXI_MASTER_TIMEOUT_EN
          wr_d       = cmd_write;
          resp_err_d = 1'b0;
`endif
          if (cmd_write) begin
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_REQ;
          end else begin
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
            state_d   = RD_REQ;
          end
        end
      end

      WR_REQ: begin
        // AW and W retire independently; a channel already done counts as complete.
        if (AWVALID && AWREADY) awvalid_d = 1'b0;
        if (WVALID && WREADY)   wvalid_d  = 1'b0;
        if ((!AWVALID || AWREADY) && (!WVALID || WREADY)) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end

      WR_RESP: begin
        if (BVALID && BREADY) begin
          bready_d     = 1'b0;
          resp_write_d = 1'b1;
          resp_rdata_d = '0;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end
      end

      RD_REQ: begin
        if (ARVALID && ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end

      RD_DATA: begin
        if (RVALID && RREADY) begin
          rready_d     = 1'b0;
          resp_write_d = 1'b0;
          resp_rdata_d = RDATA;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end
      end

      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

`ifdef AXI_MASTER_TIMEOUT_EN
    in_wait = (state_q == WR_REQ) || (state_q == WR_RESP) ||
              (state_q == RD_REQ) || (state_q == RD_DATA);

    // Expiry only overrides a state that made no progress on this edge;
    // any state change restarts the count anyway.
    if (in_wait && (tmo_cnt_q == TMO_LAST) && (state_d == state_q)) begin
      awvalid_d    = 1'b0;
      wvalid_d     = 1'b0;
      bready_d     = 1'b0;
      arvalid_d    = 1'b0;
      rready_d     = 1'b0;
      resp_write_d = wr_q;
      resp_rdata_d = '0;
      resp_valid_d = 1'b1;
      resp_err_d   = 1'b1;
      state_d      = RESP;
    end else if (in_wait && (state_d == RESP)) begin
      resp_err_d = 1'b0;
    end

    if (state_d != state_q) tmo_cnt_d = '0;
    else if (in_wait)       tmo_cnt_d = tmo_cnt_q + CW'(1);
`endif

    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= IDLE;
      cmd_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_write <= 1'b0;
      resp_rdata <= '0;
      AWADDR     <= '0;
      AWVALID    <= 1'b0;
      WDATA      <= '0;
      WVALID     <= 1'b0;
      BREADY     <= 1'b0;
      ARADDR     <= '0;
      ARVALID    <= 1'b0;
      RREADY     <= 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
      tmo_cnt_q  <= '0;
      wr_q       <= 1'b0;
      resp_err   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cmd_ready  <= cmd_ready_d;
      resp_valid <= resp_valid_d;
      resp_write <= resp_write_d;
      resp_rdata <= resp_rdata_d;
      AWADDR     <= awaddr_d;
      AWVALID    <= awvalid_d;
      WDATA      <= wdata_d;
      WVALID     <= wvalid_d;
      BREADY     <= bready_d;
      ARADDR     <= araddr_d;
      ARVALID    <= arvalid_d;
      RREADY     <= rready_d;
`ifdef AXI_MASTER_TIMEOUT_EN
      tmo_cnt_q  <= tmo_cnt_d;
      wr_q       <= wr_d;
      resp_err   <= resp_err_d;
`endif
    end
  end

endmodule
